// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter8
//  Purpose  : Round-robin arbiter sharing one resource among 8 requesters.
//             A grant is held while the winner keeps requesting, up to an
//             optional hold limit, and is followed by one dead cycle before
//             the next grant is issued.
//  Ports    : clk         - clock, all state updates on rising edge
//             rst_n       - asynchronous active-low reset (sync release)
//             i_en        - 1 = new grants may be issued
//             i_req[7:0]  - level-sensitive requests, bit i = requester i
//             o_gnt[7:0]  - registered one-hot grant, zero when idle
//             o_gnt_idx   - registered binary index of granted requester
//             o_gnt_valid - registered, 1 while any grant is asserted
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter8 #(
   parameter int unsigned HOLD_MAX = 16,  // max grant length in cycles, 0 = unlimited
   parameter int unsigned CNT_W    = 5    // hold counter width, 2**CNT_W > HOLD_MAX
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_en,
   input  logic [7:0] i_req,
   output logic [7:0] o_gnt,
   output logic [2:0] o_gnt_idx,
   output logic       o_gnt_valid
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] c_HOLD_LIM = CNT_W'(HOLD_MAX);
   localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

   state_t           r_state;
   logic [7:0]       r_gnt;
   logic [2:0]       r_gnt_idx;
   logic             r_gnt_valid;
   logic [CNT_W-1:0] r_hold_cnt;
   logic [2:0]       r_ptr;

   state_t           w_state_nxt;
   logic [7:0]       w_gnt_nxt;
   logic [2:0]       w_gnt_idx_nxt;
   logic             w_gnt_valid_nxt;
   logic [CNT_W-1:0] w_hold_cnt_nxt;
   logic [2:0]       w_ptr_nxt;

   logic             w_found;
   logic [2:0]       w_winner;
   logic [2:0]       w_cand;
   logic             w_release;

   // Rotating priority search: the last winner (r_ptr) ranks lowest, the
   // requester just after it ranks highest. 3-bit addition wraps 7 -> 0.
   always_comb begin
      w_found  = 1'b0;
      w_winner = 3'd0;
      w_cand   = 3'd0;
      for (int k = 1; k <= 8; k++) begin
         w_cand = r_ptr + 3'(k);
         if (!w_found && i_req[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end
   end

   // Release when the owner drops its request or the hold limit is reached.
   always_comb begin
      w_release = !i_req[r_gnt_idx];
      if ((HOLD_MAX != 0) && (r_hold_cnt == c_HOLD_LIM)) begin
         w_release = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_gnt_nxt       = r_gnt;
      w_gnt_idx_nxt   = r_gnt_idx;
      w_gnt_valid_nxt = r_gnt_valid;
      w_hold_cnt_nxt  = r_hold_cnt;
      w_ptr_nxt       = r_ptr;
      case (r_state)
         ST_IDLE: begin
            w_gnt_nxt       = 8'h00;
            w_gnt_valid_nxt = 1'b0;
            if (i_en && w_found) begin
               w_state_nxt     = ST_GRANT;
               w_gnt_nxt       = 8'h01 << w_winner;
               w_gnt_idx_nxt   = w_winner;
               w_gnt_valid_nxt = 1'b1;
               w_hold_cnt_nxt  = CNT_W'(1);
               w_ptr_nxt       = w_winner;
            end
         end
         ST_GRANT: begin
            if (w_release) begin
               // gnt_idx keeps its last value through the dead cycle.
               w_state_nxt     = ST_IDLE;
               w_gnt_nxt       = 8'h00;
               w_gnt_valid_nxt = 1'b0;
               w_hold_cnt_nxt  = '0;
            end else if (r_hold_cnt != c_CNT_MAX) begin
               w_hold_cnt_nxt  = r_hold_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_gnt_nxt       = 8'h00;
            w_gnt_valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_gnt       <= 8'h00;
         r_gnt_idx   <= 3'd0;
         r_gnt_valid <= 1'b0;
         r_hold_cnt  <= '0;
         r_ptr       <= 3'd7;   // first search begins at requester 0
      end else begin
         r_state     <= w_state_nxt;
         r_gnt       <= w_gnt_nxt;
         r_gnt_idx   <= w_gnt_idx_nxt;
         r_gnt_valid <= w_gnt_valid_nxt;
         r_hold_cnt  <= w_hold_cnt_nxt;
         r_ptr       <= w_ptr_nxt;
      end
   end

   assign o_gnt       = r_gnt;
   assign o_gnt_idx   = r_gnt_idx;
   assign o_gnt_valid = r_gnt_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arbiter8
//  Purpose  : Self-checking bench for rr_arbiter8. Two instances share the
//             same stimulus: one with HOLD_MAX=16, one with HOLD_MAX=1.
//             A behavioural model tracks owner / pointer / grant age.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] req;

   logic [7:0] gnt_a, gnt_b;
   logic [2:0] idx_a, idx_b;
   logic       vld_a, vld_b;

   int checks   = 0;
   int failures = 0;

   rr_arbiter8 #(.HOLD_MAX(16), .CNT_W(5)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .i_en(en), .i_req(req),
      .o_gnt(gnt_a), .o_gnt_idx(idx_a), .o_gnt_valid(vld_a)
   );

   rr_arbiter8 #(.HOLD_MAX(1), .CNT_W(5)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .i_en(en), .i_req(req),
      .o_gnt(gnt_b), .o_gnt_idx(idx_b), .o_gnt_valid(vld_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: who owns the resource, how long, and who won last.
   int lim    [2] = '{16, 1};
   int m_busy [2];
   int m_idx  [2];
   int m_ptr  [2];
   int m_age  [2];

   task automatic model_reset();
      for (int n = 0; n < 2; n++) begin
         m_busy[n] = 0; m_idx[n] = 0; m_ptr[n] = 7; m_age[n] = 0;
      end
   endtask

   task automatic model_edge();
      int c;
      for (int n = 0; n < 2; n++) begin
         if (m_busy[n] != 0) begin
            if (!req[m_idx[n]] || (lim[n] != 0 && m_age[n] >= lim[n]))
               m_busy[n] = 0;
            else
               m_age[n] = m_age[n] + 1;
         end else if (en && req != 8'h00) begin
            for (int k = 1; k <= 8; k++) begin
               c = (m_ptr[n] + k) % 8;
               if (m_busy[n] == 0 && req[c]) begin
                  m_busy[n] = 1; m_idx[n] = c; m_ptr[n] = c; m_age[n] = 1;
               end
            end
         end
      end
   endtask

   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic [7:0] eg;
      for (int n = 0; n < 2; n++) begin
         eg = (m_busy[n] != 0) ? (8'h01 << m_idx[n]) : 8'h00;
         chk(n == 0 ? "gnt_a" : "gnt_b", n == 0 ? gnt_a : gnt_b, eg);
         chk(n == 0 ? "idx_a" : "idx_b", {5'd0, n == 0 ? idx_a : idx_b}, 8'(m_idx[n]));
         chk(n == 0 ? "vld_a" : "vld_b", {7'd0, n == 0 ? vld_a : vld_b}, {7'd0, m_busy[n] != 0});
      end
   endtask

   // One clock: inputs are already set; update the model on the edge, then
   // compare shortly after the edge.
   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge(); else model_reset();
      #1;
      check_model();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      req   = 8'hFF;
      model_reset();
      #1;
      // 1: reset with all requests active
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("reset_gnt", gnt_a, 8'h00);
         chk("reset_idx", {5'd0, idx_a}, 8'h00);
      end
      rst_n = 1'b1;
      req   = 8'h00;
      step();

      // 2: single requester 4, held 3 cycles
      req = 8'h10;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("single_gnt", gnt_a, 8'h10);
         chk("single_idx", {5'd0, idx_a}, 8'h04);
      end
      req = 8'h00;
      step();
      chk("single_rel", gnt_a, 8'h00);

      // 3: rotation on the HOLD_MAX=1 instance
      do_reset();
      req = 8'hFF;
      for (int g = 0; g < 9; g++) begin
         step();
         chk("rot_idx", {5'd0, idx_b}, 8'(g % 8));
         chk("rot_vld", {7'd0, vld_b}, 8'h01);
         step();
         chk("rot_dead", gnt_b, 8'h00);
      end

      // 4: timeout on the HOLD_MAX=16 instance
      do_reset();
      req = 8'h05;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 16; i++) begin
            step();
            chk("tmo_gnt", gnt_a, (r == 1) ? 8'h04 : 8'h01);
         end
         step();
         chk("tmo_dead", gnt_a, 8'h00);
      end

      // 5: enable gating
      do_reset();
      req = 8'h00;
      step();
      en  = 1'b0;
      req = 8'h80;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("en_block", gnt_a, 8'h00);
      end
      en = 1'b1;
      step();
      chk("en_grant", gnt_a, 8'h80);
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("en_hold", gnt_a, 8'h80);
      end
      req = 8'h00;
      step();
      chk("en_rel", gnt_a, 8'h00);

      // 6: asynchronous reset in the middle of a grant
      en  = 1'b1;
      req = 8'h20;
      step();
      chk("mid_grant", gnt_a, 8'h20);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("mid_async", gnt_a, 8'h00);
      check_model();
      step();
      rst_n = 1'b1;
      req   = 8'h21;
      step();
      chk("mid_first", gnt_a, 8'h01);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         req = 8'($urandom) & 8'($urandom);
         en  = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 3) != 0 && req != 8'h00)
            req = req | 8'($urandom);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
